// File: rtl/mrelbp_pkg.sv
// Shared types and helpers for the MRELBP-NI code generator.
package mrelbp_pkg;

    typedef logic [15:0] q8_8_t;

    localparam logic [3:0] RIU2_NONUNIFORM = 4'd9;
    localparam int         NUM_NEIGH       = 8;

    // Number of set bits in an 8-bit code.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/mrelbp_code_gen_riu2_mapper.sv
// Rotation-invariant uniform (riu2) label from an 8-bit circular LBP code.
module riu2_mapper
    import mrelbp_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] label
);

    logic [7:0] rot;
    logic [3:0] trans;

    // Circular 0/1 transitions between adjacent neighbours.
    assign rot   = {code[0], code[7:1]};
    assign trans = popcount8(code ^ rot);

    // Uniform patterns (at most 2 transitions) are labelled by their ones count.
    assign label = (trans <= 4'd2) ? popcount8(code) : RIU2_NONUNIFORM;

endmodule

// File: rtl/mrelbp_code_gen.sv
// MRELBP-NI code generator: align -> mean -> threshold/label, 3-stage valid/ready pipeline.
module mrelbp_code_gen
    import mrelbp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FIXED = 24,
    parameter int FRAC  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_q_ne_0,
    input  logic [WIDTH-1:0] i_q_ne_2,
    input  logic [WIDTH-1:0] i_q_ne_4,
    input  logic [WIDTH-1:0] i_q_ne_6,
    input  logic [FIXED-1:0] i_q_ne_1,
    input  logic [FIXED-1:0] i_q_ne_3,
    input  logic [FIXED-1:0] i_q_ne_5,
    input  logic [FIXED-1:0] i_q_ne_7,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_code,
    output logic [3:0]       o_label,
    output logic [15:0]      o_mean
);

    logic                        adv;
    q8_8_t [NUM_NEIGH-1:0]       aligned;
    q8_8_t [NUM_NEIGH-1:0]       s1_v;
    q8_8_t [NUM_NEIGH-1:0]       s2_v;
    logic                        s1_valid;
    logic                        s2_valid;
    logic [18:0]                 sum;
    q8_8_t                       s2_mean;
    logic [7:0]                  code;
    logic [3:0]                  label;

    function automatic q8_8_t align_int(input logic [WIDTH-1:0] p);
        return q8_8_t'({p, {FRAC{1'b0}}});
    endfunction

    // Interpolated samples above 255.996 cannot be represented in Q8.8 and clamp to max.
    function automatic q8_8_t align_fix(input logic [FIXED-1:0] x);
        if (|x[FIXED-1:16]) return 16'hFFFF;
        return x[15:0];
    endfunction

    // The whole pipeline moves together; a stalled output freezes every stage.
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    // Bring every neighbour into the common Q8.8 format.
    always_comb begin
        aligned    = '0;
        aligned[0] = align_int(i_q_ne_0);
        aligned[1] = align_fix(i_q_ne_1);
        aligned[2] = align_int(i_q_ne_2);
        aligned[3] = align_fix(i_q_ne_3);
        aligned[4] = align_int(i_q_ne_4);
        aligned[5] = align_fix(i_q_ne_5);
        aligned[6] = align_int(i_q_ne_6);
        aligned[7] = align_fix(i_q_ne_7);
    end

    // Stage 1: register aligned neighbours.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_v     <= '0;
        end else if (adv) begin
            s1_valid <= i_valid;
            s1_v     <= aligned;
        end
    end

    // 19-bit sum cannot overflow for 8 x 16-bit operands.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_NEIGH; k++) begin
            sum = sum + 19'(s1_v[k]);
        end
    end

    // Stage 2: register neighbours with their truncated mean.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_v     <= '0;
            s2_mean  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_v     <= s1_v;
            s2_mean  <= sum[18:3];
        end
    end

    // Threshold each neighbour against the mean.
    always_comb begin
        code = '0;
        for (int k = 0; k < NUM_NEIGH; k++) begin
            code[k] = (s2_v[k] >= s2_mean);
        end
    end

    riu2_mapper u_riu2 (
        .code  (code),
        .label (label)
    );

    // Stage 3: output registers, held while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_code  <= '0;
            o_label <= '0;
            o_mean  <= '0;
        end else if (adv) begin
            o_valid <= s2_valid;
            o_code  <= code;
            o_label <= label;
            o_mean  <= s2_mean;
        end
    end

endmodule

// File: tb/tb_mrelbp_code_gen.sv
// Self-checking bench for mrelbp_code_gen with a queue-based reference model.
module tb_mrelbp_code_gen;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_ready;
    logic        o_ready, o_valid;
    logic [7:0]  i_q_ne_0, i_q_ne_2, i_q_ne_4, i_q_ne_6;
    logic [23:0] i_q_ne_1, i_q_ne_3, i_q_ne_5, i_q_ne_7;
    logic [7:0]  o_code;
    logic [3:0]  o_label;
    logic [15:0] o_mean;

    mrelbp_code_gen dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_q_ne_0 (i_q_ne_0),
        .i_q_ne_2 (i_q_ne_2),
        .i_q_ne_4 (i_q_ne_4),
        .i_q_ne_6 (i_q_ne_6),
        .i_q_ne_1 (i_q_ne_1),
        .i_q_ne_3 (i_q_ne_3),
        .i_q_ne_5 (i_q_ne_5),
        .i_q_ne_7 (i_q_ne_7),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_code   (o_code),
        .o_label  (o_label),
        .o_mean   (o_mean)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [3:0]  label;
        logic [15:0] mean;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        dir_exp;
    logic [23:0] nb [8];
    logic [23:0] bp [5][8];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          use_dir  = 0;
    bit          check_lat = 0;
    bit          last_acc;
    logic        obs_ready;
    int          idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference: integer arithmetic straight from the MRELBP-NI definition.
    function automatic exp_t ref_model();
        exp_t r;
        int   v [8];
        int   sum, mean, ones, trans;
        bit   b [8];
        sum = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) v[k] = int'(nb[k][7:0]) * 256;
            else            v[k] = (int'(nb[k]) > 65535) ? 65535 : int'(nb[k]);
            sum += v[k];
        end
        mean = sum / 8;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            b[k] = (v[k] >= mean);
            if (b[k]) ones++;
        end
        trans = 0;
        for (int k = 0; k < 8; k++) if (b[k] != b[(k + 1) % 8]) trans++;
        r.code = '0;
        for (int k = 0; k < 8; k++) r.code[k] = b[k];
        r.label = (trans <= 2) ? 4'(ones) : 4'd9;
        r.mean  = 16'(mean);
        r.acc   = 0;
        return r;
    endfunction

    task automatic apply_nb();
        i_q_ne_0 = nb[0][7:0];
        i_q_ne_1 = nb[1];
        i_q_ne_2 = nb[2][7:0];
        i_q_ne_3 = nb[3];
        i_q_ne_4 = nb[4][7:0];
        i_q_ne_5 = nb[5];
        i_q_ne_6 = nb[6][7:0];
        i_q_ne_7 = nb[7];
    endtask

    task automatic rand_nb();
        if ($urandom_range(0, 9) == 0) begin
            logic [7:0] p;
            p = 8'($urandom_range(0, 255));
            for (int k = 0; k < 8; k++) nb[k] = (k % 2 == 0) ? {16'h0, p} : {8'h0, p, 8'h0};
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (k % 2 == 0)                     nb[k] = 24'($urandom_range(0, 255));
                else if ($urandom_range(0, 3) == 0) nb[k] = 24'($urandom);
                else                                nb[k] = 24'($urandom_range(0, 65535));
            end
        end
    endtask

    // One clock: observe (inputs already driven), score transfers, then cross the edge.
    task automatic step();
        exp_t e;
        #1;
        obs_ready = o_ready;
        last_acc  = 1'b0;
        if (i_rst) begin
            q.delete();
        end else begin
            chk("o_ready", 32'(o_ready), 32'(!o_valid || i_ready));
            if (o_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(o_valid), 32'd0);
                end else begin
                    chk("code",  32'(o_code),  32'(q[0].code));
                    chk("label", 32'(o_label), 32'(q[0].label));
                    chk("mean",  32'(o_mean),  32'(q[0].mean));
                    if (i_ready) begin
                        if (check_lat) chk("latency", 32'(cyc - q[0].acc), 32'd3);
                        void'(q.pop_front());
                    end
                end
            end
            if (i_valid && o_ready) begin
                e     = use_dir ? dir_exp : ref_model();
                e.acc = cyc;
                q.push_back(e);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic send_dir(input logic [7:0] c, input logic [3:0] l, input logic [15:0] m);
        dir_exp.code  = c;
        dir_exp.label = l;
        dir_exp.mean  = m;
        dir_exp.acc   = 0;
        i_valid = 1'b1;
        apply_nb();
        step();
    endtask

    task automatic fill(input logic [7:0] even, input logic [23:0] odd);
        for (int k = 0; k < 8; k++) nb[k] = (k % 2 == 0) ? {16'h0, even} : odd;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        fill(8'd0, 24'd0);
        apply_nb();
        @(negedge clk);
        for (int c = 0; c < 3; c++) step();
        i_rst = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_code",  32'(o_code),  32'd0);
        chk("rst_label", 32'(o_label), 32'd0);
        chk("rst_mean",  32'(o_mean),  32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);

        // Directed vectors with fixed expectations, back to back.
        use_dir = 1'b1; check_lat = 1'b1;
        fill(8'd100, 24'h006400);               send_dir(8'hFF, 4'd8, 16'h6400);
        fill(8'd0, 24'd0); nb[0] = 24'd200;     send_dir(8'h01, 4'd1, 16'h1900);
        fill(8'd100, 24'd0);                    send_dir(8'h55, 4'd9, 16'h3200);
        fill(8'd0, 24'd0); nb[1] = 24'h000080;  send_dir(8'h02, 4'd1, 16'h0010);
        nb[3] = 24'h010000;                     send_dir(8'h08, 4'd1, 16'h200F);
        fill(8'd0, 24'd0);                      send_dir(8'hFF, 4'd8, 16'h0000);
        fill(8'd255, 24'h00FF00);               send_dir(8'hFF, 4'd8, 16'hFF00);
        use_dir = 1'b0;
        drain();

        // Backpressure: five sets against a stalled sink.
        check_lat = 1'b0;
        for (int s = 0; s < 5; s++) begin
            rand_nb();
            for (int k = 0; k < 8; k++) bp[s][k] = nb[k];
        end
        i_ready = 1'b0; i_valid = 1'b1; idx = 0;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 8; k++) nb[k] = bp[idx < 5 ? idx : 4][k];
            apply_nb();
            step();
            if (last_acc) idx++;
        end
        chk("bp_accepts",   32'(idx), 32'd3);
        chk("bp_ready_low", 32'(obs_ready), 32'd0);
        i_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            for (int k = 0; k < 8; k++) nb[k] = bp[idx][k];
            apply_nb();
            step();
            if (last_acc) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'd5);
        drain();

        // Reset with two results in flight.
        check_lat = 1'b1;
        i_valid = 1'b1;
        for (int s = 0; s < 2; s++) begin rand_nb(); apply_nb(); step(); end
        i_valid = 1'b0; i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        #1;
        chk("rst_flush_valid", 32'(o_valid), 32'd0);
        i_valid = 1'b1; rand_nb(); apply_nb(); step();
        drain();

        // Randomized traffic with random backpressure.
        check_lat = 1'b0;
        for (int c = 0; c < 600; c++) begin
            i_valid = ($urandom_range(0, 9) < 7);
            i_ready = ($urandom_range(0, 9) < 7);
            rand_nb();
            apply_nb();
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
